seven_seg_scanner: RTL

//  Consumer of the 16-bit display word from the display-selection mux. Drives the
//  4-digit multiplexed common-anode 7-segment display with one hex nibble per digit.

---
 rtl/seven_seg_scanner.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// ============================================================================
//  Module   : seven_seg_scanner
//  Brief    : 4-digit multiplexed common-anode 7-segment scanner with a
//             tear-free shadow register and a programmable slot divider.
//             Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scanner #(
    parameter int unsigned CLK_DIV = 100000,
    parameter logic [3:0]  DP_MASK = 4'b0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] disp_data,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned     CNT_W      = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [6:0]      C_SEG_OFF  = 7'h7F;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_vld_q, pend_vld_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             w_tick;
    logic             w_boundary;
    logic             w_blank;
    logic [3:0]       w_nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = C_SEG_OFF;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = C_SEG_OFF;
        endcase
        return s;
    endfunction

    // Slot divider and digit index
    always_comb begin
        w_tick    = (div_cnt_q == C_DIV_LAST);
        div_cnt_d = w_tick ? '0 : div_cnt_q + CNT_W'(1);
        idx_d     = w_tick ? idx_q + 2'd1 : idx_q;
        w_boundary = w_tick && (idx_q == 2'd3);
    end

    // A load landing on the boundary bypasses pending straight into shadow.
    always_comb begin
        pending_d  = load ? disp_data : pending_q;
        pend_vld_d = pend_vld_q;
        shadow_d   = shadow_q;
        if (w_boundary) begin
            pend_vld_d = 1'b0;
            if (load) begin
                shadow_d = disp_data;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end
        end else if (load) begin
            pend_vld_d = 1'b1;
        end
        frame_done_d = w_boundary;
    end

    // Outputs are computed from the next index and next shadow so they move with idx.
    always_comb begin
        w_nibble = shadow_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank  = (idx_d != 2'd0) && ((shadow_d >> {idx_d, 2'b00}) == 16'h0000);
`else
        w_blank  = 1'b0;
`endif
        if (w_blank) begin
            an_d  = 4'hF;
            seg_d = C_SEG_OFF;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = hex_to_seg(w_nibble);
            dp_d  = ~DP_MASK[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 16'h0000;
            pend_vld_q   <= 1'b0;
            shadow_q     <= 16'h0000;
            an_q         <= 4'hF;
            seg_q        <= C_SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_vld_q   <= pend_vld_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

`default_nettype wire
